// File: rtl/cutie_actmem_pkg.sv
// Shared activation-memory constants and the scheduler arbitration-policy encoding.
package cutie_actmem_pkg;

   localparam int unsigned ACTMEM_DATA_WIDTH = 104;
   localparam int unsigned ACTMEM_BANKDEPTH  = 1024;

   typedef enum logic {
      WR_PRIO = 1'b0,
      RD_PRIO = 1'b1
   } policy_e;

endpackage

// File: rtl/actmem_rsp_fifo.sv
// In-order read-response buffer; pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module actmem_rsp_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 104,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A push into a full buffer is only accepted when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/actmem_access_scheduler.sv
// Single-port bank arbiter: write-priority with bounded read starvation, credit-limited reads.
module actmem_access_scheduler
   import cutie_actmem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = ACTMEM_DATA_WIDTH,
   parameter int unsigned BANKDEPTH    = ACTMEM_BANKDEPTH,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned RESP_DEPTH   = 2,
   localparam int unsigned ADDR_WIDTH  = $clog2(BANKDEPTH),
   localparam int unsigned SW          = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // write requester
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   // read requester
   input  logic                  rd_valid_i,
   output logic                  rd_ready_o,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   // read response
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
   // bank port, one-cycle read latency
   output logic                  bank_req_o,
   output logic                  bank_we_o,
   output logic [ADDR_WIDTH-1:0] bank_addr_o,
   output logic [DATA_WIDTH-1:0] bank_wdata_o,
   input  logic [DATA_WIDTH-1:0] bank_rdata_i,
   // status
   output logic                  busy_o,
   output logic [SW-1:0]         starve_cnt_o,
   output policy_e               dbg_state_o
);

   // Handshakes: a transfer happens on a cycle where valid and ready are both high.
   // Each ready never depends on its own valid; neither depends on rsp_ready_i.

   localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

   policy_e               state_q, state_d;
   logic [SW-1:0]         starve_q, starve_d;
   logic                  inflight_q;
   logic                  wr_gnt, rd_gnt, rd_ok, rd_wins, starve_hit;
   logic                  rd_eligible;
   logic [CW:0]           used_slots;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [DATA_WIDTH-1:0] fifo_data;

   // Credits come from registered occupancy only, so a response pop frees a slot next cycle.
   assign used_slots  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
   assign rd_eligible = (used_slots < (CW+1)'(RESP_DEPTH)) && !fifo_full;
   assign starve_hit  = (starve_q >= SW'(STARVE_LIMIT));
   assign rd_ok       = rd_valid_i && rd_eligible;

   always_comb begin
      wr_ready_o = 1'b0;
      rd_ready_o = 1'b0;
      wr_gnt     = 1'b0;
      rd_gnt     = 1'b0;
      rd_wins    = 1'b0;
      state_d    = state_q;
      starve_d   = starve_q;
      if (!rst_i) begin
         rd_wins    = (state_q == RD_PRIO) || starve_hit;
         wr_ready_o = !(rd_ok && rd_wins);
         rd_ready_o = rd_eligible && (rd_wins || !wr_valid_i);
         wr_gnt     = wr_valid_i && wr_ready_o;
         rd_gnt     = rd_valid_i && rd_ready_o;

         // Only writes that overtake an eligible read count toward starvation.
         if (!rd_valid_i || rd_gnt) begin
            starve_d = '0;
         end else if (wr_gnt && rd_ok && !starve_hit) begin
            starve_d = starve_q + SW'(1);
         end

         if (rd_gnt) begin
            state_d = WR_PRIO;
         end else if (wr_gnt && rd_ok && (starve_q + SW'(1) == SW'(STARVE_LIMIT))) begin
            state_d = RD_PRIO;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= WR_PRIO;
         starve_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         inflight_q <= rd_gnt;
      end
   end

   assign bank_req_o   = wr_gnt || rd_gnt;
   assign bank_we_o    = wr_gnt;
   assign bank_addr_o  = wr_gnt ? wr_addr_i : (rd_gnt ? rd_addr_i : '0);
   assign bank_wdata_o = wr_gnt ? wr_data_i : '0;

   // Returning data bypasses the buffer when it is empty and the consumer is ready.
   assign fifo_push = !rst_i && inflight_q && !(fifo_empty && rsp_ready_i);
   assign fifo_pop  = !rst_i && !fifo_empty && rsp_ready_i;

   actmem_rsp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (bank_rdata_i),
      .pop_i   (fifo_pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign rsp_valid_o  = !rst_i && (inflight_q || !fifo_empty);
   assign rsp_data_o   = fifo_empty ? bank_rdata_i : fifo_data;
   assign busy_o       = !rst_i && (inflight_q || !fifo_empty);
   assign starve_cnt_o = rst_i ? '0 : starve_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_actmem_access_scheduler.sv
// Bench for actmem_access_scheduler: bank model, directed scenarios, random traffic, scoreboard.
module tb_actmem_access_scheduler;
   import cutie_actmem_pkg::*;

   localparam int DW    = 104;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;
   localparam int LIMIT = 4;
   localparam int RDEP  = 2;
   localparam int SW    = 3;

   // clock / reset
   logic clk = 1'b0;
   logic rst_i = 1'b1;
   initial forever #5 clk = ~clk;

   logic          wr_valid_i = 1'b0, rd_valid_i = 1'b0, rsp_ready_i = 1'b0;
   logic [AW-1:0] wr_addr_i = '0, rd_addr_i = '0;
   logic [DW-1:0] wr_data_i = '0;
   logic          wr_ready_o, rd_ready_o, rsp_valid_o, bank_req_o, bank_we_o, busy_o;
   logic [DW-1:0] rsp_data_o, bank_wdata_o;
   logic [DW-1:0] bank_rdata = '0;
   logic [AW-1:0] bank_addr_o;
   logic [SW-1:0] starve_cnt_o;
   policy_e       dbg_state_o;

   actmem_access_scheduler #(
      .DATA_WIDTH(DW), .BANKDEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .RESP_DEPTH(RDEP)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_addr_i(rd_addr_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
      .bank_req_o(bank_req_o), .bank_we_o(bank_we_o), .bank_addr_o(bank_addr_o),
      .bank_wdata_o(bank_wdata_o), .bank_rdata_i(bank_rdata),
      .busy_o(busy_o), .starve_cnt_o(starve_cnt_o), .dbg_state_o(dbg_state_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // bank model: synchronous write, one-cycle registered read
   logic [DW-1:0] bank_mem [DEPTH];
   logic [DW-1:0] ref_mem  [DEPTH];
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         bank_mem[i] = '0;
         ref_mem[i]  = '0;
      end
   end

   always @(posedge clk) begin
      if (bank_req_o) begin
         if (bank_we_o) bank_mem[bank_addr_o] = bank_wdata_o;
         else bank_rdata <= bank_mem[bank_addr_o];
      end
   end

   // scoreboard: reference policy, memory contents and outstanding responses
   logic [DW-1:0] exp_q[$];
   int            cyc_q[$];
   int            cyc = 0;
   int            ref_streak = 0;
   bit            ref_rd_pri = 1'b0;
   bit            m_elig, m_rd, m_wr, m_rvalid;
   bit            stall_q = 1'b0;
   logic [DW-1:0] stall_data, m_head;
   logic [AW-1:0] m_addr;

   always @(negedge clk) begin
      if (rst_i) begin
         check("reset_outputs",
               128'({wr_ready_o, rd_ready_o, rsp_valid_o, bank_req_o, bank_we_o, busy_o, starve_cnt_o}), 128'(0));
         exp_q.delete();
         cyc_q.delete();
         ref_streak = 0;
         ref_rd_pri = 1'b0;
         stall_q    = 1'b0;
      end else begin
         // a read may be accepted only while fewer than RDEP responses are owed
         m_elig   = (exp_q.size() < RDEP);
         m_rd     = rd_valid_i && m_elig && (ref_rd_pri || !wr_valid_i);
         m_wr     = wr_valid_i && !m_rd;
         m_addr   = m_wr ? wr_addr_i : (m_rd ? rd_addr_i : '0);
         m_rvalid = (exp_q.size() > 0) && (cyc_q[0] < cyc);

         check("starve_cnt", 128'(starve_cnt_o), 128'(ref_streak));
         check("policy_state", 128'(dbg_state_o == RD_PRIO), 128'(ref_rd_pri));
         check("rd_grant", 128'(rd_valid_i && rd_ready_o), 128'(m_rd));
         check("wr_grant", 128'(wr_valid_i && wr_ready_o), 128'(m_wr));
         check("bank_req_we", 128'({bank_req_o, bank_we_o}), 128'({m_wr || m_rd, m_wr}));
         check("bank_addr", 128'(bank_addr_o), 128'(m_addr));
         check("bank_wdata", 128'(bank_wdata_o), 128'(m_wr ? wr_data_i : '0));
         check("busy", 128'(busy_o), 128'(exp_q.size() > 0));
         check("rsp_valid", 128'(rsp_valid_o), 128'(m_rvalid));

         if (stall_q && rsp_valid_o) check("rsp_stable", 128'(rsp_data_o), 128'(stall_data));
         stall_q    = rsp_valid_o && !rsp_ready_i;
         stall_data = rsp_data_o;
         if (rsp_valid_o && rsp_ready_i && exp_q.size() > 0) begin
            m_head = exp_q.pop_front();
            void'(cyc_q.pop_front());
            check("rsp_data", 128'(rsp_data_o), 128'(m_head));
         end

         if (m_wr) ref_mem[wr_addr_i] = wr_data_i;
         if (m_rd) begin
            exp_q.push_back(ref_mem[rd_addr_i]);
            cyc_q.push_back(cyc);
         end
         if (!rd_valid_i || m_rd) ref_streak = 0;
         else if (m_wr && m_elig && ref_streak < LIMIT) begin
            ref_streak++;
            if (ref_streak == LIMIT) ref_rd_pri = 1'b1;
         end
         if (m_rd) ref_rd_pri = 1'b0;
      end
      cyc++;
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit wv, input int wa, input logic [DW-1:0] wd,
                        input bit rv, input int ra, input bit rr);
      step();
      wr_valid_i  = wv;
      wr_addr_i   = AW'(wa);
      wr_data_i   = wd;
      rd_valid_i  = rv;
      rd_addr_i   = AW'(ra);
      rsp_ready_i = rr;
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [127:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      return r[DW-1:0];
   endfunction

   int nwr, peak, granted;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      check("post_reset_idle", 128'({rsp_valid_o, busy_o, bank_req_o, starve_cnt_o}), 128'(0));

      // write-only burst: addresses 0..3, data 0xA5..0xA8
      nwr = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, i, DW'(8'hA5 + i), 1'b0, 0, 1'b1);
         @(negedge clk);
         check("burst_wr_ready", 128'(wr_ready_o), 128'(1));
         if (bank_req_o && bank_we_o && bank_addr_o == AW'(i)) nwr++;
      end
      check("burst_bank_writes", 128'(nwr), 128'(4));

      // both requesters valid: W,W,W,W,R repeating
      peak = 0;
      for (int k = 0; k < 15; k++) begin
         drive(1'b1, 100 + k, rand_data(), 1'b1, $urandom_range(0, 3), 1'b1);
         @(negedge clk);
         check("starve_pattern", 128'(rd_valid_i && rd_ready_o), 128'(k % 5 == 4));
         if (int'(starve_cnt_o) > peak) peak = int'(starve_cnt_o);
      end
      check("starve_peak", 128'(peak), 128'(4));

      // write-then-read of the same address
      drive(1'b1, 7, DW'(16'h1234), 1'b0, 0, 1'b1);
      drive(1'b0, 0, '0, 1'b1, 7, 1'b1);
      @(negedge clk);
      check("raw_read_grant", 128'(rd_ready_o), 128'(1));
      drive(1'b0, 0, '0, 1'b0, 0, 1'b1);
      @(negedge clk);
      check("raw_rsp_valid", 128'(rsp_valid_o), 128'(1));
      check("raw_rsp_data", 128'(rsp_data_o), 128'(16'h1234));

      // credit exhaustion with a stalled consumer
      for (int i = 0; i < 3; i++) drive(1'b1, 12 + i, DW'(32'hC0DE_0000 + i), 1'b0, 0, 1'b1);
      granted = 0;
      for (int c = 0; c < 6; c++) begin
         drive(1'b0, 0, '0, 1'b1, 12 + granted, 1'b0);
         @(negedge clk);
         if (rd_valid_i && rd_ready_o) granted++;
      end
      check("credit_block_grants", 128'(granted), 128'(2));
      check("credit_block_rd_ready", 128'(rd_ready_o), 128'(0));
      for (int c = 0; c < 10 && granted < 3; c++) begin
         drive(1'b0, 0, '0, 1'b1, 12 + granted, 1'b1);
         @(negedge clk);
         if (rd_valid_i && rd_ready_o) granted++;
      end
      check("credit_release_grant", 128'(granted), 128'(3));
      repeat (4) drive(1'b0, 0, '0, 1'b0, 0, 1'b1);

      // reset one cycle after a read grant drops that read
      drive(1'b0, 0, '0, 1'b1, 7, 1'b1);
      @(negedge clk);
      check("rst_case_grant", 128'(rd_ready_o), 128'(1));
      drive(1'b0, 0, '0, 1'b0, 0, 1'b1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("rst_drop_rsp", 128'({rsp_valid_o, busy_o}), 128'(0));
         step();
      end

      // randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), rand_data(),
               $urandom_range(0, 2) != 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0);
         rst_i = ($urandom_range(0, 299) == 0);
      end

      // drain outstanding responses within a bounded window
      drive(1'b0, 0, '0, 1'b0, 0, 1'b1);
      rst_i = 1'b0;
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(negedge clk);
      @(negedge clk);
      check("drain_complete", 128'(exp_q.size()), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
